tick_scheduler: RTL and testbench

//  Shares one base tick pulse (1 kHz from the tick generator) among NUM_CH software-timer channels.

---
 rtl/tick_scheduler.sv | 141 ++++++++++++++
 tb/tb_tick_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// Shares one base tick among NUM_CH software timers (periodic or one-shot) and serialises their
// expiries into a lowest-channel-first event stream with per-channel overrun flags.
module tick_scheduler #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned PERIOD_W = 16,
    localparam int unsigned CH_W    = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                base_tick,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                cfg_oneshot,
    output logic [NUM_CH-1:0]   ch_tick,
    output logic [NUM_CH-1:0]   ch_busy,
    output logic                evt_valid,
    output logic [CH_W-1:0]     evt_ch,
    input  logic                evt_ready,
    output logic [NUM_CH-1:0]   overrun
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e              state_q   [NUM_CH];
    state_e              state_d   [NUM_CH];
    logic [PERIOD_W-1:0] cnt_q     [NUM_CH];
    logic [PERIOD_W-1:0] cnt_d     [NUM_CH];
    logic [PERIOD_W-1:0] period_q  [NUM_CH];
    logic [PERIOD_W-1:0] period_d  [NUM_CH];

    logic [NUM_CH-1:0] oneshot_q, oneshot_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] overrun_q, overrun_d;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] expire;
    logic [NUM_CH-1:0] cfg_hit;
    logic [NUM_CH-1:0] cfg_clr;
    logic [NUM_CH-1:0] consume;
    logic              cfg_accept;

    // Config is refused on base_tick cycles so a write never races a counter update.
    assign cfg_ready  = ~base_tick;
    assign cfg_accept = cfg_valid & cfg_ready;

    always_comb begin
        cfg_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_hit[i] = cfg_accept && (cfg_ch == CH_W'(i));
        end
    end

    // Per-channel IDLE/RUN next state; cnt holds base ticks remaining minus one.
    always_comb begin
        expire    = '0;
        cfg_clr   = '0;
        oneshot_d = oneshot_q;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            period_d[i] = period_q[i];
            if (cfg_hit[i]) begin
                if (cfg_period != '0) begin
                    state_d[i]   = StRun;
                    cnt_d[i]     = cfg_period - PERIOD_W'(1);
                    period_d[i]  = cfg_period;
                    oneshot_d[i] = cfg_oneshot;
                    cfg_clr[i]   = 1'b1;
                end else if (state_q[i] == StRun) begin
                    state_d[i] = StIdle;
                    cnt_d[i]   = '0;
                    cfg_clr[i] = 1'b1;
                end
            end else if (state_q[i] == StRun && base_tick) begin
                if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - PERIOD_W'(1);
                end else begin
                    expire[i] = 1'b1;
                    if (oneshot_q[i]) begin
                        state_d[i] = StIdle;
                    end else begin
                        cnt_d[i] = period_q[i] - PERIOD_W'(1);
                    end
                end
            end
        end
    end

    // Lowest pending channel is presented; an expiry racing its own consume keeps one event.
    always_comb begin
        evt_ch  = '0;
        consume = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                evt_ch = CH_W'(i);
            end
        end
        if (evt_valid && evt_ready) begin
            consume[evt_ch] = 1'b1;
        end
        pending_d = (pending_q & ~consume & ~cfg_clr) | expire;
        overrun_d = (overrun_q & ~cfg_clr) | (expire & pending_q & ~consume);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= StIdle;
                cnt_q[i]    <= '0;
                period_q[i] <= '0;
            end
            oneshot_q <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            tick_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= state_d[i];
                cnt_q[i]    <= cnt_d[i];
                period_q[i] <= period_d[i];
            end
            oneshot_q <= oneshot_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            tick_q    <= expire;
        end
    end

    always_comb begin
        ch_busy = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_busy[i] = (state_q[i] == StRun);
        end
    end

    assign ch_tick   = tick_q;
    assign overrun   = overrun_q;
    assign evt_valid = |pending_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: vector table, directed corner sequences and random traffic against a
// ticks-remaining reference model.
module tb_tick_scheduler;

    localparam int NUM_CH   = 4;
    localparam int PERIOD_W = 16;
    localparam int CH_W     = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                base_tick = 1'b0;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_ch = '0;
    logic [PERIOD_W-1:0] cfg_period = '0;
    logic                cfg_oneshot = 1'b0;
    logic [NUM_CH-1:0]   ch_tick;
    logic [NUM_CH-1:0]   ch_busy;
    logic                evt_valid;
    logic [CH_W-1:0]     evt_ch;
    logic                evt_ready = 1'b0;
    logic [NUM_CH-1:0]   overrun;

    tick_scheduler #(.NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .base_tick   (base_tick),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_oneshot (cfg_oneshot),
        .ch_tick     (ch_tick),
        .ch_busy     (ch_busy),
        .evt_valid   (evt_valid),
        .evt_ch      (evt_ch),
        .evt_ready   (evt_ready),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: m_rem = base ticks still to go before the next expiry.
    logic [NUM_CH-1:0] m_run, m_os, m_pend, m_ovr, m_tick;
    int                m_rem [NUM_CH];
    int                m_per [NUM_CH];

    typedef struct {
        logic       bt;
        logic       cv;
        int         ch;
        int         per;
        logic       os;
        logic       rdy;
        logic       rdy_exp;
        logic [3:0] tick;
        logic [3:0] busy;
        logic       ev;
        int         evch;
        logic [3:0] ovr;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int lowest(input logic [NUM_CH-1:0] v);
        for (int i = 0; i < NUM_CH; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_run = '0; m_os = '0; m_pend = '0; m_ovr = '0; m_tick = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_rem[i] = 0;
            m_per[i] = 0;
        end
    endtask

    task automatic model_step();
        int                lo;
        int                c;
        logic [NUM_CH-1:0] consumed, clr, old_pend;
        lo       = lowest(m_pend);
        consumed = '0;
        if (lo >= 0 && evt_ready) consumed[lo] = 1'b1;
        old_pend = m_pend;
        m_tick   = '0;
        clr      = '0;
        if (cfg_valid && !base_tick) begin
            c = int'(cfg_ch);
            if (cfg_period != 0) begin
                m_run[c] = 1'b1;
                m_rem[c] = int'(cfg_period);
                m_per[c] = int'(cfg_period);
                m_os[c]  = cfg_oneshot;
                clr[c]   = 1'b1;
            end else if (m_run[c]) begin
                m_run[c] = 1'b0;
                clr[c]   = 1'b1;
            end
        end
        if (base_tick) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (m_run[i]) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        m_tick[i] = 1'b1;
                        if (m_os[i]) m_run[i] = 1'b0;
                        else m_rem[i] = m_per[i];
                    end
                end
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (consumed[i] || clr[i]) m_pend[i] = 1'b0;
            if (clr[i]) m_ovr[i] = 1'b0;
            if (m_tick[i]) begin
                if (old_pend[i] && !consumed[i]) m_ovr[i] = 1'b1;
                m_pend[i] = 1'b1;
            end
        end
    endtask

    task automatic compare_model();
        check("ch_tick", ch_tick, m_tick);
        check("ch_busy", ch_busy, m_run);
        check("evt_valid", evt_valid, |m_pend);
        if (|m_pend) check("evt_ch", evt_ch, lowest(m_pend));
        check("overrun", overrun, m_ovr);
    endtask

    // Called at a negedge; returns at the next negedge with registered outputs checked.
    task automatic tick(input logic bt, input logic cv, input int ch, input int per,
                        input logic os, input logic rdy, output logic rdy_seen);
        base_tick   = bt;
        cfg_valid   = cv;
        cfg_ch      = ch[CH_W-1:0];
        cfg_period  = per[PERIOD_W-1:0];
        cfg_oneshot = os;
        evt_ready   = rdy;
        #1;
        rdy_seen = cfg_ready;
        check("cfg_ready", cfg_ready, !bt);
        model_step();
        @(posedge clk);
        #1;
        compare_model();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst ch_tick", ch_tick, 0);
        check("rst ch_busy", ch_busy, 0);
        check("rst evt_valid", evt_valid, 0);
        check("rst evt_ch", evt_ch, 0);
        check("rst overrun", overrun, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic seen;

    initial begin
        //           bt    cv    ch per os    rdy   rdyx  tick     busy     ev   ch ovr
        tbl[0]  = '{1'b0, 1'b1, 2, 1, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0100, 1'b0, 0, 4'b0000};
        tbl[1]  = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b1, 2, 4'b0000};
        tbl[2]  = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 0, 4'b0000};
        tbl[3]  = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 0, 4'b0000};
        tbl[4]  = '{1'b0, 1'b1, 1, 2, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0010, 1'b0, 0, 4'b0000};
        tbl[5]  = '{1'b0, 1'b1, 3, 2, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1010, 1'b0, 0, 4'b0000};
        tbl[6]  = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1010, 1'b0, 0, 4'b0000};
        tbl[7]  = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 4'b1010, 4'b1010, 1'b1, 1, 4'b0000};
        tbl[8]  = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1010, 1'b1, 3, 4'b0000};
        tbl[9]  = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1010, 1'b0, 0, 4'b0000};
        tbl[10] = '{1'b1, 1'b1, 1, 0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1010, 1'b0, 0, 4'b0000};
        tbl[11] = '{1'b0, 1'b1, 1, 0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1000, 1'b0, 0, 4'b0000};
        tbl[12] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, 1'b1, 3, 4'b0000};
        tbl[13] = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b1, 3, 4'b0000};
        tbl[14] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1000, 1'b1, 3, 4'b0000};
        tbl[15] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, 1'b1, 3, 4'b1000};
        tbl[16] = '{1'b0, 1'b1, 3, 0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 0, 4'b0000};

        model_reset();
        #2;
        do_reset();

        for (int i = 0; i < 17; i++) begin
            tick(tbl[i].bt, tbl[i].cv, tbl[i].ch, tbl[i].per, tbl[i].os, tbl[i].rdy, seen);
            check($sformatf("tbl%0d cfg_ready", i), seen, tbl[i].rdy_exp);
            check($sformatf("tbl%0d ch_tick", i), ch_tick, tbl[i].tick);
            check($sformatf("tbl%0d ch_busy", i), ch_busy, tbl[i].busy);
            check($sformatf("tbl%0d evt_valid", i), evt_valid, tbl[i].ev);
            if (tbl[i].ev) check($sformatf("tbl%0d evt_ch", i), evt_ch, tbl[i].evch);
            check($sformatf("tbl%0d overrun", i), overrun, tbl[i].ovr);
        end

        // Periodic P=3 with base_tick every 10 clocks.
        tick(1'b0, 1'b1, 0, 3, 1'b0, 1'b1, seen);
        for (int k = 1; k <= 9; k++) begin
            tick(1'b1, 1'b0, 0, 0, 1'b0, 1'b1, seen);
            check($sformatf("p3 tick%0d", k), ch_tick[0], (k % 3) == 0);
            check($sformatf("p3 busy%0d", k), ch_busy[0], 1);
            for (int j = 0; j < 9; j++) tick(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, seen);
        end
        tick(1'b0, 1'b1, 0, 0, 1'b0, 1'b1, seen);
        check("p3 stopped", ch_busy[0], 0);

        // Overrun: three expiries with the consumer stalled leave one event.
        tick(1'b0, 1'b1, 0, 1, 1'b0, 1'b0, seen);
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, seen);
            tick(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, seen);
        end
        check("ovr evt_valid", evt_valid, 1);
        check("ovr evt_ch", evt_ch, 0);
        check("ovr flag", overrun[0], 1);
        tick(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, seen);
        check("ovr single event", evt_valid, 0);
        check("ovr sticky", overrun[0], 1);
        tick(1'b0, 1'b1, 0, 4, 1'b0, 1'b0, seen);
        check("ovr cleared", overrun[0], 0);
        check("ovr rearmed", ch_busy[0], 1);
        tick(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, seen);

        // Reset mid-operation.
        tick(1'b0, 1'b1, 0, 2, 1'b0, 1'b0, seen);
        tick(1'b0, 1'b1, 1, 3, 1'b0, 1'b0, seen);
        tick(1'b0, 1'b1, 2, 1, 1'b0, 1'b0, seen);
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, seen);
        check("pre-rst pending", evt_valid, 1);
        check("pre-rst overrun", overrun[2], 1);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            tick(1'b1, 1'b0, 0, 0, 1'b0, 1'b1, seen);
            check("post-rst tick", ch_tick, 0);
            check("post-rst evt", evt_valid, 0);
        end
        tick(1'b0, 1'b1, 1, 1, 1'b0, 1'b1, seen);
        tick(1'b1, 1'b0, 0, 0, 1'b0, 1'b1, seen);
        check("rearm tick", ch_tick, 4'b0010);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            logic bt, cv, os, rdy;
            int   per;
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                bt  = ($urandom_range(0, 3) == 0);
                cv  = ($urandom_range(0, 5) == 0);
                os  = $urandom_range(0, 1);
                rdy = ($urandom_range(0, 2) != 0);
                per = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 65535))
                                                   : int'($urandom_range(0, 6));
                tick(bt, cv, int'($urandom_range(0, NUM_CH - 1)), per, os, rdy, seen);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
